ni_tx_qdi: RTL and testbench

- Clocked network-interface transmitter that injects flits from a synchronous core into the local input port of the asynchronous SDM router.
- Buffers valid/ready flits in a small FIFO.
- Encodes each flit as 1-of-4 QDI rails plus an eof rail.
- Runs a four-phase return-to-zero handshake against the router's asynchronous input ack, sampled through a synchroniser.
- Single virtual circuit (wormhole); one instance per router local port.

---
 rtl/ni_tx_qdi.sv | 212 +++++++++++++++++++++
 tb/tb_ni_tx_qdi.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_tx_qdi.sv
// ni_tx_qdi: clocked network-interface transmitter into an async QDI router.
// Buffers flits in a FIFO and emits 1-of-4 + eof rails with four-phase RTZ.
module ni_tx_qdi #(
  parameter int DW    = 32,
  parameter int SCN   = DW/2,
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  in_data,
  input  logic           in_eof,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [SCN-1:0] lo0,
  output logic [SCN-1:0] lo1,
  output logic [SCN-1:0] lo2,
  output logic [SCN-1:0] lo3,
  output logic           lo4,
  input  logic           loa,
  output logic           busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(SYNC + 1);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] FILL_ONE = CW'(1);
  localparam logic [CW-1:0] FILL_END = CW'(SYNC);

  typedef enum logic [2:0] {
    RWAIT,
    IDLE,
    DATA,
    DNULL,
    EOFT,
    ENULL
  } state_t;

  logic [SYNC-1:0] sync_q, sync_d;
  logic            ack_s;

  logic [DW:0]     mem_q [DEPTH];
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            push, pop;
  logic            full, empty;
  logic [DW:0]     head;

  state_t          st_q, st_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic [SCN-1:0]  r0_q, r0_d;
  logic [SCN-1:0]  r1_q, r1_d;
  logic [SCN-1:0]  r2_q, r2_d;
  logic [SCN-1:0]  r3_q, r3_d;
  logic            r4_q, r4_d;
  logic [SCN-1:0]  e0, e1, e2, e3;

  assign sync_d = {sync_q[SYNC-2:0], loa};
  assign ack_s  = sync_q[SYNC-1];

  assign full     = (cnt_q == CNT_FULL);
  assign empty    = (cnt_q == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rp_q];

  assign busy = !rst && (!empty || (st_q != IDLE));

  assign lo0 = r0_q;
  assign lo1 = r1_q;
  assign lo2 = r2_q;
  assign lo3 = r3_q;
  assign lo4 = r4_q;

  always_comb begin
    e0 = '0;
    e1 = '0;
    e2 = '0;
    e3 = '0;
    for (int i = 0; i < SCN; i++) begin
      unique case (head[2*i +: 2])
        2'd0: e0[i] = 1'b1;
        2'd1: e1[i] = 1'b1;
        2'd2: e2[i] = 1'b1;
        2'd3: e3[i] = 1'b1;
      endcase
    end
  end

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) wp_d = wp_q + PTR_ONE;
    if (pop)  rp_d = rp_q + PTR_ONE;
    if (push && !pop)
      cnt_d = cnt_q + CNT_ONE;
    else if (pop && !push)
      cnt_d = cnt_q - CNT_ONE;
  end

  always_comb begin
    st_d   = st_q;
    fill_d = fill_q;
    r0_d   = r0_q;
    r1_d   = r1_q;
    r2_d   = r2_q;
    r3_d   = r3_q;
    r4_d   = r4_q;
    pop    = 1'b0;
    unique case (st_q)
      RWAIT: begin
        r0_d = '0;
        r1_d = '0;
        r2_d = '0;
        r3_d = '0;
        r4_d = 1'b0;
        // let the cleared chain refill so ack_s reflects the live ack
        if (fill_q != FILL_END)
          fill_d = fill_q + FILL_ONE;
        else if (!ack_s)
          st_d = IDLE;
      end
      IDLE: begin
        if (!empty) begin
          r0_d = e0;
          r1_d = e1;
          r2_d = e2;
          r3_d = e3;
          st_d = DATA;
        end
      end
      DATA: begin
        if (ack_s) begin
          r0_d = '0;
          r1_d = '0;
          r2_d = '0;
          r3_d = '0;
          st_d = DNULL;
        end
      end
      DNULL: begin
        if (!ack_s) begin
          if (head[DW]) begin
            r4_d = 1'b1;
            st_d = EOFT;
          end else begin
            pop  = 1'b1;
            st_d = IDLE;
          end
        end
      end
      EOFT: begin
        if (ack_s) begin
          r4_d = 1'b0;
          st_d = ENULL;
        end
      end
      ENULL: begin
        if (!ack_s) begin
          pop  = 1'b1;
          st_d = IDLE;
        end
      end
      default: begin
        r0_d = '0;
        r1_d = '0;
        r2_d = '0;
        r3_d = '0;
        r4_d = 1'b0;
        st_d = RWAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {in_eof, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      st_q   <= RWAIT;
      fill_q <= '0;
      r0_q   <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      r3_q   <= '0;
      r4_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      fill_q <= fill_d;
      r0_q   <= r0_d;
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      r3_q   <= r3_d;
      r4_q   <= r4_d;
    end
  end

endmodule

// File: tb/tb_ni_tx_qdi.sv
// tb_ni_tx_qdi: bench for ni_tx_qdi with a router ack model and a
// token-level scoreboard that decodes the rails back into flits.
module tb_ni_tx_qdi;

  localparam int DW    = 32;
  localparam int SCN   = DW/2;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  in_data;
  logic           in_eof;
  logic           in_valid;
  logic           in_ready;
  logic [SCN-1:0] lo0, lo1, lo2, lo3;
  logic           lo4;
  logic           loa = 1'b0;
  logic           busy;

  always #5 clk = ~clk;

  ni_tx_qdi #(
    .DW(DW), .SCN(SCN), .DEPTH(DEPTH), .SYNC(SYNC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_eof(in_eof),
    .in_valid(in_valid), .in_ready(in_ready),
    .lo0(lo0), .lo1(lo1), .lo2(lo2), .lo3(lo3),
    .lo4(lo4), .loa(loa), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW:0] exp_q [$];

  bit   force_en  = 1'b0;
  logic force_val = 1'b0;
  bit   rnd_dly   = 1'b0;
  int   fix_dly   = 3;
  int   cd        = -1;
  int   lcnt      = 0;
  bit   prev_tok  = 1'b0;
  logic [4*SCN:0] prev_r = '0;

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Router model: acks each token after a delay, releases after the null.
  // lcnt counts clock edges since loa last changed.
  always @(negedge clk) begin : rtr
    logic [4*SCN:0] r;
    logic [DW:0]    dec;
    bit             tok;
    bit             ok;
    int             nh;
    logic           nxt;
    r   = {lo4, lo3, lo2, lo1, lo0};
    tok = |r;
    lcnt++;
    if (rst) begin
      prev_tok = 1'b0;
    end else begin
      if (tok && !prev_tok) begin
        chk("tok_setup", 80'(!loa && (lcnt >= SYNC + 1)), 80'd1);
        ok  = 1'b1;
        dec = '0;
        if (lo4) begin
          ok = ({lo3, lo2, lo1, lo0} == '0);
          dec[DW] = 1'b1;
        end else begin
          for (int i = 0; i < SCN; i++) begin
            nh = int'(lo0[i]) + int'(lo1[i]) + int'(lo2[i]) + int'(lo3[i]);
            if (nh != 1) ok = 1'b0;
            dec[2*i +: 2] = lo3[i] ? 2'd3 : lo2[i] ? 2'd2 :
                            lo1[i] ? 2'd1 : 2'd0;
          end
        end
        chk("one_of_4", 80'(ok), 80'd1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_tok: got %0h want none", dec);
        end else begin
          chk("token", 80'(dec), 80'(exp_q.pop_front()));
        end
      end
      if (tok && prev_tok)
        chk("hold", 80'(r), 80'(prev_r));
      if (!tok && prev_tok)
        chk("ack_to_clear", 80'(loa && (lcnt == SYNC + 1)), 80'd1);
    end
    prev_tok = tok;
    prev_r   = r;
    nxt = loa;
    if (force_en) begin
      nxt = force_val;
      cd  = -1;
    end else if (loa != tok) begin
      if (cd < 0) cd = rnd_dly ? int'($urandom_range(5, 0)) : fix_dly;
      if (cd == 0) begin
        nxt = tok;
        cd  = -1;
      end else begin
        cd--;
      end
    end else begin
      cd = -1;
    end
    if (nxt !== loa) begin
      loa  = nxt;
      lcnt = 0;
    end
  end

  task automatic offer(input logic [DW-1:0] d, input bit e,
                       input int max, output bit ok);
    ok       = 1'b0;
    in_data  = d;
    in_eof   = e;
    in_valid = 1'b1;
    for (int k = 0; k < max && !ok; k++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back({1'b0, d});
        if (e) exp_q.push_back({1'b1, {DW{1'b0}}});
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int max);
    int k;
    k = 0;
    while (busy && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 80'(busy), 80'd0);
    chk({nm, "_sb"}, 80'(exp_q.size()), 80'd0);
  endtask

  typedef struct {
    logic [DW-1:0]  d;
    logic [SCN-1:0] l0, l1, l2, l3;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k;
    tbl[0] = '{32'h0000_00E4, 16'hFFF1, 16'h0002, 16'h0004, 16'h0008};
    tbl[1] = '{32'hFFFF_FFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    tbl[2] = '{32'h0000_0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    tbl[3] = '{32'h5555_5555, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[4] = '{32'hAAAA_AAAA, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    tbl[5] = '{32'h1B1B_1B1B, 16'h8888, 16'h4444, 16'h2222, 16'h1111};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_eof   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rails", 80'({lo4, lo3, lo2, lo1, lo0}), 80'd0);
    chk("rst_ready", 80'(in_ready), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 80'(in_ready), 80'd1);
    @(negedge clk);
    wait_idle("rwait_exit", 20);

    for (int t = 0; t < 6; t++) begin
      offer(tbl[t].d, 1'b0, 4, ok);
      chk("tbl_accept", 80'(ok), 80'd1);
      @(negedge clk);
      chk("tbl_lo0", 80'(lo0), 80'(tbl[t].l0));
      chk("tbl_lo1", 80'(lo1), 80'(tbl[t].l1));
      chk("tbl_lo2", 80'(lo2), 80'(tbl[t].l2));
      chk("tbl_lo3", 80'(lo3), 80'(tbl[t].l3));
      chk("tbl_lo4", 80'(lo4), 80'd0);
      wait_idle("tbl_drain", 60);
    end

    offer(32'hFFFF_FFFF, 1'b1, 4, ok);
    chk("tail_accept", 80'(ok), 80'd1);
    @(negedge clk);
    chk("tail_lo3", 80'(lo3), 80'hFFFF);
    k = 0;
    while (!lo4 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("tail_eof_up", 80'(lo4), 80'd1);
    chk("tail_eof_data0", 80'({lo3, lo2, lo1, lo0}), 80'd0);
    k = 0;
    while (lo4 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("tail_eof_down", 80'(lo4), 80'd0);
    chk("tail_busy_enull", 80'(busy), 80'd1);
    wait_idle("tail_drain", 60);

    force_en  = 1'b1;
    force_val = 1'b0;
    for (int n = 0; n < DEPTH; n++) begin
      offer(32'hB000_0000 + DW'(n), 1'b0, 2, ok);
      chk("bp_accept", 80'(ok), 80'd1);
    end
    chk("bp_ready_full", 80'(in_ready), 80'd0);
    offer(32'hB000_0004, 1'b0, 6, ok);
    chk("bp_held", 80'(ok), 80'd0);
    chk("bp_still_full", 80'(in_ready), 80'd0);
    force_en = 1'b0;
    offer(32'hB000_0004, 1'b0, 300, ok);
    chk("bp_fifth", 80'(ok), 80'd1);
    wait_idle("bp_drain", 400);

    force_en  = 1'b1;
    force_val = 1'b0;
    offer(32'h1234_5678, 1'b0, 4, ok);
    @(negedge clk);
    chk("rt_token_up", 80'(|{lo3, lo2, lo1, lo0}), 80'd1);
    force_val = 1'b1;
    @(negedge clk);
    #1;
    chk("rt_pre", 80'(loa && (|{lo3, lo2, lo1, lo0})), 80'd1);
    rst = 1'b1;
    #1;
    chk("rt_async_clear", 80'({lo4, lo3, lo2, lo1, lo0}), 80'd0);
    chk("rt_ready", 80'(in_ready), 80'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    offer(32'hCAFE_F00D, 1'b0, 4, ok);
    chk("rt_accept", 80'(ok), 80'd1);
    repeat (10) @(negedge clk);
    chk("rt_no_token", 80'({lo4, lo3, lo2, lo1, lo0}), 80'd0);
    chk("rt_busy", 80'(busy), 80'd1);
    force_en = 1'b0;
    wait_idle("rt_drain", 100);

    rnd_dly = 1'b1;
    for (int n = 0; n < 64; n++) begin
      offer(DW'($urandom), ($urandom_range(3, 0) == 0), 300, ok);
      chk("rnd_accept", 80'(ok), 80'd1);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    wait_idle("rnd_drain", 2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
